// File: rtl/audio_dac_serializer.sv
// I2S transmit serializer for the audio CODEC DAC path: a small stereo-pair FIFO feeding a
// shift register timed by the codec-mastered BCLK/LRCK, oversampled on the system clock.
module audio_dac_serializer #(
  parameter int DW    = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     write,
  input  logic [DW-1:0]            writedata_left,
  input  logic [DW-1:0]            writedata_right,
  output logic                     write_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     underflow,
  input  logic                     AUD_BCLK,
  input  logic                     AUD_DACLRCK,
  output logic                     AUD_DACDAT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DW + 1);

  // Codec clock synchronizers: [0],[1] resolve metastability, [2] is the previous sample.
  logic [2:0] bclk_sync;
  logic [2:0] lr_sync;
  logic       bclk_fall;
  logic       lr_fall;
  logic       lr_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      bclk_sync <= {bclk_sync[1:0], AUD_BCLK};
      lr_sync   <= {lr_sync[1:0], AUD_DACLRCK};
    end
  end

  assign bclk_fall = bclk_sync[2] & ~bclk_sync[1];
  assign lr_fall   = lr_sync[2] & ~lr_sync[1];
  assign lr_rise   = ~lr_sync[2] & lr_sync[1];

  // FIFO storage and pointers; pointers wrap naturally because DEPTH is a power of two.
  logic [DW-1:0] mem_l [DEPTH];
  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;

  assign push = write & write_ready;
  assign pop  = lr_fall & (fifo_count != '0);

  // NOTE: the sample memory has no reset; contents are only visible through a valid pop.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_l[wr_ptr] <= writedata_left;
      mem_r[wr_ptr] <= writedata_right;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns count_next and no latch is inferred.
    count_next = fifo_count;
    case ({push, pop})
      2'b10:   count_next = fifo_count + 1'b1;
      2'b01:   count_next = fifo_count - 1'b1;
      default: count_next = fifo_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      write_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count  <= count_next;
      write_ready <= (count_next != CW'(DEPTH));
    end
  end

  // Serializer: LR edges load a channel, BCLK falls shift it out MSB first.
  logic [DW-1:0] shreg;
  logic [DW-1:0] held_r;
  logic [BW-1:0] bit_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg      <= '0;
      held_r     <= '0;
      bit_cnt    <= '0;
      underflow  <= 1'b0;
      AUD_DACDAT <= 1'b0;
    end else begin
      underflow <= lr_fall & ~pop;
      if (lr_fall) begin
        shreg   <= pop ? mem_l[rd_ptr] : '0;
        held_r  <= pop ? mem_r[rd_ptr] : '0;
        bit_cnt <= '0;
      end else if (lr_rise) begin
        shreg   <= held_r;
        bit_cnt <= '0;
      end else if (bclk_fall) begin
        if (bit_cnt != BW'(DW)) begin
          AUD_DACDAT <= shreg[DW-1];
          shreg      <= {shreg[DW-2:0], 1'b0};
          bit_cnt    <= bit_cnt + 1'b1;
        end else begin
          AUD_DACDAT <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Self-checking bench for audio_dac_serializer: codec clocks generated here, DACDAT captured on
// BCLK rising edges and compared against a queue-based model of the I2S frame.
module tb_audio_dac_serializer;

  localparam int DW    = 24;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          write = 1'b0;
  logic [DW-1:0] writedata_left = '0;
  logic [DW-1:0] writedata_right = '0;
  logic          write_ready;
  logic [2:0]    fifo_count;
  logic          underflow;
  logic          bclk = 1'b1;
  logic          lrck = 1'b1;
  logic          dacdat;

  audio_dac_serializer #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .write_ready     (write_ready),
    .fifo_count      (fifo_count),
    .underflow       (underflow),
    .AUD_BCLK        (bclk),
    .AUD_DACLRCK     (lrck),
    .AUD_DACDAT      (dacdat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  pair_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    under_cycles = 0;

  always @(posedge clk) if (underflow === 1'b1) under_cycles <= under_cycles + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
    pair_t p;
    @(negedge clk);
    check("write_ready", 64'(write_ready), 64'(q.size() < DEPTH));
    write = 1'b1;
    writedata_left = l;
    writedata_right = r;
    @(negedge clk);
    write = 1'b0;
    if (q.size() < DEPTH) begin
      p.l = l;
      p.r = r;
      q.push_back(p);
    end
    check("fifo_count_push", 64'(fifo_count), 64'(q.size()));
  endtask

  // One I2S frame: 64 BCLKs of 12 clk each; LRCK changes together with a BCLK fall.
  task automatic run_frame(input bit push_at_pop);
    logic [63:0] cap;
    logic [63:0] exp;
    pair_t       p;
    pair_t       np;
    bit          exp_under;
    int          u0;
    cap = '0;
    u0 = under_cycles;
    p.l = '0;
    p.r = '0;
    np.l = 24'($urandom);
    np.r = 24'($urandom);
    exp_under = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      bclk = 1'b0;
      if (k == 0)  lrck = 1'b0;
      if (k == 32) lrck = 1'b1;
      for (int c = 1; c < 6; c++) begin
        @(negedge clk);
        if (k == 0 && c == 2 && push_at_pop) begin
          write = 1'b1;
          writedata_left = np.l;
          writedata_right = np.r;
        end
        if (k == 0 && c == 3) begin
          bit acc;
          write = 1'b0;
          acc = (q.size() < DEPTH);
          if (q.size() > 0) p = q.pop_front();
          else exp_under = 1'b1;
          if (push_at_pop && acc) q.push_back(np);
          check("fifo_count_pop", 64'(fifo_count), 64'(q.size()));
        end
      end
      @(negedge clk);
      cap = {cap[62:0], dacdat};
      bclk = 1'b1;
      repeat (5) @(negedge clk);
    end
    exp = {1'b0, p.l, 7'b0, 1'b0, p.r, 7'b0};
    check("frame_bits", cap, exp);
    check("underflow_cycles", 64'(under_cycles - u0), 64'(exp_under));
  endtask

  initial begin
    #12;
    check("rst_write_ready", 64'(write_ready), 64'd1);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_dacdat", 64'(dacdat), 64'd0);
    check("rst_underflow", 64'(underflow), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Directed serialization with asymmetric MSB/LSB patterns.
    push(24'h800001, 24'h7FFFFE);
    run_frame(1'b0);

    // Empty FIFO at frame start.
    run_frame(1'b0);

    // Fill past capacity with LRCK idle, then drain in order.
    for (int i = 0; i < 5; i++) push(24'($urandom), 24'($urandom));
    check("full_count", 64'(fifo_count), 64'(DEPTH));
    check("full_write_ready", 64'(write_ready), 64'd0);
    for (int i = 0; i < 4; i++) run_frame(1'b0);

    // Push and pop in the same cycle at count 2, wrapping the pointers several times.
    push(24'($urandom), 24'($urandom));
    push(24'($urandom), 24'($urandom));
    for (int i = 0; i < 10; i++) run_frame(1'b1);
    run_frame(1'b0);
    run_frame(1'b0);

    // Reset in the middle of a left half that is driving ones.
    push(24'hFFFFFF, 24'hFFFFFF);
    @(negedge clk);
    bclk = 1'b0;
    lrck = 1'b0;
    repeat (6) @(negedge clk);
    bclk = 1'b1;
    repeat (6) @(negedge clk);
    bclk = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_reset_msb", 64'(dacdat), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_write_ready", 64'(write_ready), 64'd1);
    check("mid_rst_fifo_count", 64'(fifo_count), 64'd0);
    check("mid_rst_dacdat", 64'(dacdat), 64'd0);
    q.delete();
    bclk = 1'b1;
    lrck = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    run_frame(1'b0);

    // Randomized traffic.
    for (int i = 0; i < 8; i++) begin
      int n;
      n = int'($urandom_range(0, 2));
      for (int j = 0; j < n; j++) push(24'($urandom), 24'($urandom));
      run_frame(1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
